// File: rtl/sobel_window_loader.sv
// sobel_window_loader
//   Raster-order pixel loader for the Sobel gx window calculators. Keeps two
//   line buffers (rows y-1 and y-2) and a 3-row x 4-column shift window.
//   Each accepted pixel shifts in one new column. enable_calc pulses for
//   every window that lies entirely inside the current frame.
//   Optional feature macro: SOBEL_WINDOW_CNT_EN adds a 20-bit window_count
//   output that counts the windows emitted in the current frame.
//   dbg_state exposes the FSM state (IDLE=0, PRIME=1, STREAM=2, DONE=3).
//   Handshake: a pixel is transferred on a rising edge where pixel_valid and
//   pixel_ready are both high. pixel_ready depends only on the state and on
//   calc_stall, never on pixel_valid.
module sobel_window_loader #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic [7:0]       pixel_in,
   input  logic             pixel_valid,
   output logic             pixel_ready,
   input  logic             calc_stall,
   output logic [11:0][7:0] data_buffer,
   output logic             enable_calc,
   output logic             frame_done,
   output logic [1:0]       dbg_state
`ifdef SOBEL_WINDOW_CNT_EN
   ,
   output logic [19:0]      window_count
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRIME  = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [11:0][7:0]  win_q, win_d;
   logic              en_q, en_d;

   // Line buffers carry no reset: every entry is written before it is read
   // into a window that gets flagged.
   logic [7:0]        lb0 [IMG_WIDTH];
   logic [7:0]        lb1 [IMG_WIDTH];

   logic              accept;
   logic              last_col;
   logic              last_row;
   logic              complete;

   assign pixel_ready = ((state_q == S_PRIME) || (state_q == S_STREAM)) && !calc_stall;
   assign accept      = pixel_valid && pixel_ready;
   assign last_col    = (col_q == CW'(IMG_WIDTH - 1));
   assign last_row    = (row_q == RW'(IMG_HEIGHT - 1));
   // Needing col >= 3 also hides the stale columns left over from the
   // previous row right after a row wrap.
   assign complete    = accept && (row_q >= RW'(2)) && (col_q >= CW'(3));

   assign data_buffer = win_q;
   assign enable_calc = en_q;
   assign frame_done  = (state_q == S_DONE);
   assign dbg_state   = state_q;

   // Next-state logic: FSM transitions, raster counters and window shift
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      en_d    = complete;

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_PRIME;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_PRIME: begin
            if (accept && last_col && (row_q == RW'(1))) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (accept && last_col && last_row) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         win_d[8:0] = win_q[11:3];
         win_d[9]   = lb1[col_q];
         win_d[10]  = lb0[col_q];
         win_d[11]  = pixel_in;
         if (last_col) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // State, counter and window registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         win_q   <= win_d;
         en_q    <= en_d;
      end
   end

   // Line buffer update: the row above moves down, the new pixel becomes row y-1
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col_q] <= lb0[col_q];
         lb0[col_q] <= pixel_in;
      end
   end

`ifdef SOBEL_WINDOW_CNT_EN
   logic [19:0] cnt_q, cnt_d;

   // Window counter: counts on the completing edge so it already includes the
   // window that is visible together with frame_done
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == S_IDLE) && frame_start) cnt_d = '0;
      else if (complete)                      cnt_d = cnt_q + 20'd1;
   end

   // Window counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign window_count = cnt_q;
`endif

endmodule

// File: tb/tb_sobel_window_loader.sv
// tb_sobel_window_loader
//   Directed bench for sobel_window_loader at 8x4. The bench holds the frame
//   image, works out each expected window straight from that image when the
//   completing pixel is driven, queues it, and compares it when enable_calc
//   shows up. Builds with or without SOBEL_WINDOW_CNT_EN.
module tb_sobel_window_loader;

   localparam int W = 8;
   localparam int H = 4;

   logic             clk;
   logic             rst;
   logic             frame_start;
   logic [7:0]       pixel_in;
   logic             pixel_valid;
   logic             pixel_ready;
   logic             calc_stall;
   logic [11:0][7:0] data_buffer;
   logic             enable_calc;
   logic             frame_done;
   logic [1:0]       dbg_state;
`ifdef SOBEL_WINDOW_CNT_EN
   logic [19:0]      window_count;
`endif

   sobel_window_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pixel_in    (pixel_in),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .calc_stall  (calc_stall),
      .data_buffer (data_buffer),
      .enable_calc (enable_calc),
      .frame_done  (frame_done),
      .dbg_state   (dbg_state)
`ifdef SOBEL_WINDOW_CNT_EN
      ,
      .window_count(window_count)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int           checks = 0;
   int           errors = 0;
   logic [111:0] exp_q[$];          // {y, x, window}
   logic [7:0]   img [H][W];
   int           bx, by;
   bit           armed, in_done;
   int           pulses, accepts, pattern;
   logic [95:0]  last_exp;
   bit           hold_ok;
   logic [19:0]  cnt_exp;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] window_at(input int y, input int x);
      logic [95:0] w;
      w = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 3; r++)
            w[(c*3+r)*8 +: 8] = img[y-2+r][x-3+c];
      return w;
   endfunction

   // One clock: predict ready/accept before the edge, check outputs after it.
   task automatic tick();
      logic         ready_exp;
      bit           acc, win, last, fs_ok;
      logic [111:0] e;
      logic [95:0]  edge_exp;
      @(negedge clk);
      ready_exp = armed && !calc_stall;
      chk("pixel_ready", 96'(pixel_ready), 96'(ready_exp));
      fs_ok = frame_start && !armed && !in_done;
      acc   = pixel_valid && ready_exp;
      win   = 0;
      last  = 0;
      if (acc) begin
         accepts++;
         if (by >= 2 && bx >= 3) begin
            exp_q.push_back({8'(by), 8'(bx), window_at(by, bx)});
            win = 1;
            cnt_exp++;
         end
         if (bx == W-1 && by == H-1) last = 1;
         if (bx == W-1) begin bx = 0; by++; end
         else bx++;
         if (last) armed = 0;
      end
      if (fs_ok) begin
         armed   = 1;
         bx      = 0;
         by      = 0;
         cnt_exp = 0;
      end
      in_done = last;
      @(posedge clk);
      #1;
      chk("enable_calc", 96'(enable_calc), 96'(win));
      chk("frame_done", 96'(frame_done), 96'(last));
      if (enable_calc === 1'b1) begin
         pulses++;
         chk("window_queue_depth", 96'(exp_q.size()), 96'(1));
         if (pulses == 1) chk("first_window_accept", 96'(accepts), 96'(20));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_buffer", data_buffer, e[95:0]);
            last_exp = e[95:0];
            hold_ok  = 1;
            if (pattern == 0 && pulses == 1) begin
               chk("ramp_first_b0", 96'(data_buffer[0]), 96'h00);
               chk("ramp_first_b2", 96'(data_buffer[2]), 96'h20);
               chk("ramp_first_b11", 96'(data_buffer[11]), 96'h23);
            end
            if (pattern == 1 && e[111:104] == 8'd2 && e[103:96] == 8'd5) begin
               for (int i = 0; i < 12; i++) edge_exp[i*8 +: 8] = (i < 6) ? 8'd100 : 8'd200;
               chk("edge_window_r2c5", data_buffer, edge_exp);
            end
            if (pattern == 1 && e[111:104] == 8'd2 && e[103:96] == 8'd3) begin
               for (int i = 0; i < 12; i++) edge_exp[i*8 +: 8] = 8'd100;
               chk("edge_window_r2c3", data_buffer, edge_exp);
            end
         end
      end else begin
         if (acc) hold_ok = 0;
         else if (hold_ok) chk("data_buffer_hold", data_buffer, last_exp);
      end
      if (last) begin
         chk("pulses_at_done", 96'(pulses), 96'(10));
         chk("accepts_at_done", 96'(accepts), 96'(32));
      end
`ifdef SOBEL_WINDOW_CNT_EN
      chk("window_count", 96'(window_count), 96'(cnt_exp));
`endif
   endtask

   // Asserts reset in the middle of a low clock phase and checks it acts at once.
   task automatic do_reset();
      pixel_valid = 0;
      frame_start = 0;
      calc_stall  = 0;
      pixel_in    = '0;
      @(negedge clk);
      #2;
      rst = 1;
      #1;
      chk("rst_data_buffer", data_buffer, 96'h0);
      chk("rst_enable_calc", 96'(enable_calc), 96'h0);
      chk("rst_frame_done", 96'(frame_done), 96'h0);
      chk("rst_pixel_ready", 96'(pixel_ready), 96'h0);
      chk("rst_state_idle", 96'(dbg_state), 96'h0);
`ifdef SOBEL_WINDOW_CNT_EN
      chk("rst_window_count", 96'(window_count), 96'h0);
`endif
      exp_q.delete();
      armed    = 0;
      in_done  = 0;
      last_exp = '0;
      hold_ok  = 1;
      cnt_exp  = '0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   // Drives one frame. stall_y/stall_x: where to hold calc_stall for 3 cycles;
   // poke: pulse frame_start mid-STREAM; abort_after: stop after that many accepts.
   task automatic run_frame(input int stall_y, input int stall_x, input bit poke, input int abort_after);
      int stalls;
      int guard;
      bit poked;
      pulses      = 0;
      accepts     = 0;
      stalls      = 3;
      guard       = 0;
      poked       = 0;
      frame_start = 1;
      pixel_valid = 0;
      tick();
      frame_start = 0;
      pixel_valid = 1;
      while (armed && guard < 200) begin
         if (abort_after > 0 && accepts == abort_after) break;
         pixel_in   = img[by][bx];
         calc_stall = (by == stall_y && bx == stall_x && stalls > 0);
         if (calc_stall) stalls--;
         frame_start = poke && !poked && by == 2 && bx == 1;
         if (frame_start) poked = 1;
         tick();
         guard++;
      end
      frame_start = 0;
      calc_stall  = 0;
      pixel_valid = 0;
      chk("frame_cycle_budget", 96'(guard >= 200), 96'(0));
      if (abort_after == 0) begin
         tick();
         chk("pulses_total", 96'(pulses), 96'(10));
      end
   endtask

   task automatic fill(input int pat);
      pattern = pat;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            case (pat)
               0:       img[y][x] = 8'(y*16 + x);
               1:       img[y][x] = (x < 4) ? 8'd100 : 8'd200;
               default: img[y][x] = 8'($urandom_range(0, 255));
            endcase
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 0; frame_start = 0; pixel_in = '0; pixel_valid = 0; calc_stall = 0;
      bx = 0; by = 0; armed = 0; in_done = 0; pulses = 0; accepts = 0; pattern = 0;
      last_exp = '0; hold_ok = 1; cnt_exp = '0;

      // reset, then valid high in IDLE must not be accepted
      do_reset();
      pixel_valid = 1;
      pixel_in    = 8'h55;
      for (int i = 0; i < 3; i++) tick();
      pixel_valid = 0;

      // ramp frame
      fill(0);
      run_frame(-1, -1, 0, 0);
      for (int i = 0; i < 2; i++) tick();

      // vertical edge frame
      fill(1);
      run_frame(-1, -1, 0, 0);

      // random frame with a 3-cycle stall in row 2
      fill(2);
      run_frame(2, 5, 0, 0);

      // abort after 22 accepts, then a full ramp frame with a stray frame_start
      fill(2);
      run_frame(-1, -1, 0, 22);
      do_reset();
      fill(0);
      run_frame(-1, -1, 1, 0);
      for (int i = 0; i < 2; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sobel_window_loader.md
# sobel_window_loader

Producer side of the Sobel gx window interface. Accepts a raster-order 8-bit pixel stream and keeps two line buffers. Assembles a sliding 3-row × 4-column window into the 12-byte `data_buffer` bus, and pulses `enable_calc` once per complete window for the downstream gx window calculators. Sits between the pixel input stage and the gx/gy block windows.

## Interface

- `IMG_WIDTH`, 640, pixels per row; legal values ≥ 4
- `IMG_HEIGHT`, 480, rows per frame; legal values ≥ 3
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse; arms a new frame (honoured in IDLE only)
- `pixel_in`  in  8  unsigned pixel
- `pixel_valid`  in  1  `pixel_in` is valid
- `pixel_ready`  out  1  loader accepts a pixel this cycle
- `calc_stall`  in  1  downstream busy; forces `pixel_ready` low
- `data_buffer`  out  [11:0][7:0]  window, column-major: `data_buffer[c*3+r]`
  - c = 0 is the oldest column, c = 3 the newest
  - r = 0 is row y-2, r = 2 is the current row y
- `enable_calc`  out  1  one-cycle pulse; `data_buffer` holds a complete window
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame

## Operation

- **Accept:** a pixel is accepted on a rising edge where `pixel_valid && pixel_ready`.
- **`pixel_ready`:** equals `(state==PRIME || state==STREAM) && !calc_stall`. It is combinational from state and `calc_stall`.
- **Line buffers:** two arrays of `IMG_WIDTH` × 8 bits.
  - `lb0` holds row y-1; `lb1` holds row y-2.
  - Contents are not reset and are don't-care until written.
- **On each accept at column x:**
  - window shifts one column: c0←c1, c1←c2, c2←c3
  - new c3 = {r0=`lb1[x]`, r1=`lb0[x]`, r2=`pixel_in`}
  - `lb1[x]`←`lb0[x]`; `lb0[x]`←`pixel_in`
  - col increments; at `IMG_WIDTH-1` col wraps to 0 and row increments
- **Window complete:** an accept with row ≥ 2 and col ≥ 3. The window then covers columns x-3..x and rows y-2..y.
- **Row wrap:** stale columns from the previous row remain in the shift register. They are never flagged, because completion requires col ≥ 3.
- **Window counts:** `IMG_WIDTH-3` windows per row; `(IMG_HEIGHT-2)*(IMG_WIDTH-3)` per frame.
- **State machine:**
  - IDLE: on `frame_start` → PRIME; col and row cleared
  - PRIME: rows 0–1; on accepting the last pixel of row 1 → STREAM
  - STREAM: rows 2..H-1; on accepting pixel (W-1, H-1) → DONE
  - DONE: one cycle, then → IDLE
- **`frame_start` outside IDLE:** ignored.
- **Counter widths:** col is `$clog2(IMG_WIDTH)` bits; row is `$clog2(IMG_HEIGHT)` bits. There is no arithmetic on pixel data.

## Timing

- **Reset values:**
  - `data_buffer` = 0, `enable_calc` = 0, `frame_done` = 0
  - `pixel_ready` = 0; state = IDLE; counters = 0
- **Reset mid-frame:** discards the partial frame; a new `frame_start` is required.
- **Window latency:** `data_buffer` and `enable_calc` are registered and update on the accepting edge. The window is visible, with `enable_calc` high, in the cycle after acceptance, i.e. one clock of latency.
- **`enable_calc`:** high exactly one cycle per completing accept. During non-accepting cycles (stall, valid low) it is low and `data_buffer` holds.
- **Back-to-back accepts:** `enable_calc` stays high on consecutive cycles, each with a new window.
- **Frame end:** `frame_done` (Moore, DONE state) is high in the same cycle as the final `enable_calc`.
- **First accept of a new frame:** the earliest is one cycle after `frame_start` (PRIME entered on that edge).
- **`calc_stall`:** takes effect in the same cycle. No pixel is lost or duplicated across a stall.

## Configuration

- **`SOBEL_WINDOW_CNT_EN` defined:** adds output `window_count` (20 bits).
  - cleared on reset and when `frame_start` is honoured
  - increments on each `enable_calc` pulse
  - holds its final frame total after DONE
- **`SOBEL_WINDOW_CNT_EN` undefined:** port and counter are absent; all other behaviour is identical.

## Test plan

All scenarios use `IMG_WIDTH`=8 and `IMG_HEIGHT`=4.

1. **Reset:** assert `rst` mid-cycle → all outputs 0 immediately; `pixel_ready`=0 in IDLE until `frame_start`.
2. **Ramp frame:** `pixel_in` = row*16+col, `pixel_valid` held high.
   - first `enable_calc` follows the 20th accept (row 2, col 3), with `data_buffer[0]`=0x00, `[2]`=0x20, `[11]`=0x23
   - exactly 10 pulses total
   - `frame_done` coincides with the 10th pulse, after the 32nd accept
3. **Vertical edge:** cols 0–3 = 100, cols 4–7 = 200.
   - window at (row 2, col 5): `data_buffer[0..5]`=100, `[6..11]`=200
   - window at (row 2, col 3): all twelve bytes = 100
4. **Stall:** raise `calc_stall` for 3 cycles during row 2 with `pixel_valid` high.
   - `pixel_ready`=0, no `enable_calc`, `data_buffer` held during the stall
   - afterwards the sequence resumes and the total is still 10 pulses
5. **Abort and restart:** assert `rst` after 22 accepts, then `frame_start` and a full frame.
   - first `enable_calc` again follows the 20th accept; 10 pulses
   - `frame_start` pulsed during STREAM is ignored
6. **Counter macro:** with `SOBEL_WINDOW_CNT_EN`, `window_count`=10 at `frame_done`. It stays 10 in IDLE and returns to 0 on the next `frame_start`.
